carry_resolve: RTL and testbench



---
 rtl/carry_resolve_pkg.sv | 17 +
 rtl/carry_resolve_limb_add.sv | 17 +
 rtl/carry_resolve.sv | 122 ++++++++++++
 tb/tb_carry_resolve.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carry_resolve_pkg.sv
// Shared constants, state type and sizing helper for the carry_resolve block.
package carry_resolve_pkg;

    localparam int RADIX_DEF = 108;
    localparam int SIZE_DEF  = 3072;
    localparam int LPC_DEF   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/carry_resolve_limb_add.sv
// One radix-bit limb of the carry chain: s = a + b + carry_in, with carry out.
module carry_resolve_limb_add #(
    parameter int WIDTH = 108
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH:0] w_total;

    assign w_total          = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_carry};
    assign {o_carry, o_sum} = w_total;

endmodule

// File: rtl/carry_resolve.sv
// Limb-serial carry-save to binary resolver: LPC limbs per clock, registered carry between groups.
// Optional sticky err output for dropped start pulses: define CARRY_RESOLVE_ERR_EN.
module carry_resolve
    import carry_resolve_pkg::*;
#(
    parameter int Size  = SIZE_DEF,
    parameter int radix = RADIX_DEF,
    parameter int LPC   = LPC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [Size+radix+1:0] r0,
    input  logic [Size+radix+1:0] r1,
    output logic [Size+radix+2:0] sum,
    output logic                  busy,
    output logic                  done
`ifdef CARRY_RESOLVE_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int W     = Size + radix + 2;
    localparam int LIMBS = ceil_div(W, radix);
    localparam int G     = ceil_div(LIMBS, LPC);
    localparam int STEP  = LPC * radix;
    localparam int PW    = G * STEP;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;

    state_t          r_state;
    logic [PW-1:0]   r_op0;
    logic [PW-1:0]   r_op1;
    logic [W:0]      r_sum;
    logic            r_carry;
    logic            r_done;
    logic [GW-1:0]   r_gidx;

    logic [LPC:0]    w_carry;
    logic [STEP:0]   w_grp;
    logic [W:0]      w_sumNext;

    // The operand registers shift down one group per cycle, so the adders always see the low STEP bits.
    assign w_carry[0] = r_carry;

    for (genvar j = 0; j < LPC; j++) begin : g_limb
        carry_resolve_limb_add #(
            .WIDTH(radix)
        ) u_add (
            .i_a    (r_op0[j*radix +: radix]),
            .i_b    (r_op1[j*radix +: radix]),
            .i_carry(w_carry[j]),
            .o_sum  (w_grp[j*radix +: radix]),
            .o_carry(w_carry[j+1])
        );
    end

    assign w_grp[STEP] = w_carry[LPC];

    // The last group's slice reaches bit W; that bit is the padded chain's bit W, i.e. the final carry.
    for (genvar g = 0; g < G; g++) begin : g_grp
        localparam int LO = g * STEP;
        localparam int HI = (g == G - 1) ? W : (LO + STEP - 1);
        assign w_sumNext[HI:LO] = (r_gidx == GW'(g)) ? w_grp[HI-LO:0] : r_sum[HI:LO];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op0   <= '0;
            r_op1   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_gidx  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en && !r_done) begin
                        r_op0   <= PW'(r0);
                        r_op1   <= PW'(r1);
                        r_carry <= 1'b0;
                        r_gidx  <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_op0   <= r_op0 >> STEP;
                    r_op1   <= r_op1 >> STEP;
                    r_carry <= w_carry[LPC];
                    r_sum   <= w_sumNext;
                    r_gidx  <= r_gidx + 1'b1;
                    if (r_gidx == GW'(G - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sum  = r_sum;
    assign busy = (r_state == RUN);
    assign done = r_done;

`ifdef CARRY_RESOLVE_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (en && ((r_state == RUN) || r_done)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_carry_resolve.sv
// Bench for carry_resolve: three builds (LPC=2, 1, 4) share one stimulus stream and are checked against r0+r1.
module tb_carry_resolve;

    localparam int SIZE   = 3072;
    localparam int RADIX  = 108;
    localparam int W      = SIZE + RADIX + 2;
    localparam int LIMBS  = (W + RADIX - 1) / RADIX;
    localparam int NDUT   = 3;
    localparam int BUDGET = 40;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic [W:0]   sumO [NDUT];
    logic         busyO[NDUT];
    logic         doneO[NDUT];
`ifdef CARRY_RESOLVE_ERR_EN
    logic         errO [NDUT];
`endif

    int checks = 0;
    int errors = 0;

    int         gotLat [NDUT];
    int         gotBusy[NDUT];
    int         gotDone[NDUT];
    logic [W:0] gotSum [NDUT];
    logic [W:0] gotSumEnd[NDUT];
    logic [W:0] rstSumSeen[NDUT];
    logic       rstBusySeen[NDUT];

    always #5 clk = ~clk;

    carry_resolve #(.Size(SIZE), .radix(RADIX), .LPC(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .r0(r0), .r1(r1),
        .sum(sumO[0]), .busy(busyO[0]), .done(doneO[0])
`ifdef CARRY_RESOLVE_ERR_EN
        , .err(errO[0])
`endif
    );

    carry_resolve #(.Size(SIZE), .radix(RADIX), .LPC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .r0(r0), .r1(r1),
        .sum(sumO[1]), .busy(busyO[1]), .done(doneO[1])
`ifdef CARRY_RESOLVE_ERR_EN
        , .err(errO[1])
`endif
    );

    carry_resolve #(.Size(SIZE), .radix(RADIX), .LPC(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .r0(r0), .r1(r1),
        .sum(sumO[2]), .busy(busyO[2]), .done(doneO[2])
`ifdef CARRY_RESOLVE_ERR_EN
        , .err(errO[2])
`endif
    );

    function automatic int lpcOf(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int expLat(input int d);
        return (LIMBS + lpcOf(d) - 1) / lpcOf(d);
    endfunction

    function automatic logic [W-1:0] randWide();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    function automatic logic [W:0] refSum(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic int firstDiff(input logic [W:0] x);
        for (int i = 0; i <= W; i++) begin
            if (x[0]) return i;
            x = x >> 1;
        end
        return -1;
    endfunction

    // Starts one operation and records per-build latency, busy cycles, done pulses and sums.
    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int rp1, input int rp2, input int rstAt);
        for (int d = 0; d < NDUT; d++) begin
            gotLat[d]  = -1;
            gotBusy[d] = 0;
            gotDone[d] = 0;
            gotSum[d]  = '0;
        end
        r0 = a;
        r1 = b;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        r0 = randWide();
        r1 = randWide();
        for (int n = 0; n <= BUDGET; n++) begin
            for (int d = 0; d < NDUT; d++) begin
                if (busyO[d]) gotBusy[d]++;
                if (doneO[d]) begin
                    gotDone[d]++;
                    if (gotLat[d] < 0) begin
                        gotLat[d] = n;
                        gotSum[d] = sumO[d];
                    end
                end
            end
            en = (n == rp1) || (n == rp2);
            if (n == rstAt) begin
                rst_n = 1'b0;
                #1;
                for (int d = 0; d < NDUT; d++) begin
                    rstSumSeen[d]  = sumO[d];
                    rstBusySeen[d] = busyO[d];
                end
            end
            if (n == rstAt + 2) rst_n = 1'b1;
            @(negedge clk);
        end
        en = 1'b0;
        for (int d = 0; d < NDUT; d++) gotSumEnd[d] = sumO[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (sumO[d] !== '0) begin
                errors++;
                $display("[TB] FAIL reset_sum dut%0d: got low %h, expected 0", d, sumO[d][31:0]);
            end
            checks++;
            if (busyO[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_busy dut%0d: got %b, expected 0", d, busyO[d]);
            end
            checks++;
            if (doneO[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_done dut%0d: got %b, expected 0", d, doneO[d]);
            end
`ifdef CARRY_RESOLVE_ERR_EN
            checks++;
            if (errO[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_err dut%0d: got %b, expected 0", d, errO[d]);
            end
`endif
        end
    endtask

    task automatic test_zero();
        runOp('0, '0, -1, -1, -1);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (gotLat[d] !== expLat(d)) begin
                errors++;
                $display("[TB] FAIL zero_latency dut%0d: got %0d, expected %0d", d, gotLat[d], expLat(d));
            end
            checks++;
            if (gotSum[d] !== '0) begin
                errors++;
                $display("[TB] FAIL zero_sum dut%0d: got low %h, expected 0", d, gotSum[d][31:0]);
            end
        end
    endtask

    task automatic test_ripple();
        logic [W:0] exp;
        exp    = '0;
        exp[W] = 1'b1;
        runOp({W{1'b1}}, W'(1), -1, -1, -1);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (gotLat[d] !== expLat(d)) begin
                errors++;
                $display("[TB] FAIL ripple_latency dut%0d: got %0d, expected %0d", d, gotLat[d], expLat(d));
            end
            checks++;
            if (gotSum[d] !== exp) begin
                errors++;
                $display("[TB] FAIL ripple_sum dut%0d: first wrong bit %0d, got msb %b, expected msb 1",
                         d, firstDiff(gotSum[d] ^ exp), gotSum[d][W]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
        for (int k = 0; k < 200; k++) begin
            a = randWide();
            case (k % 4)
                0:       b = ~a;
                1:       b = ~a + W'(1);
                default: b = randWide();
            endcase
            exp = refSum(a, b);
            runOp(a, b, -1, -1, -1);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (gotLat[d] !== expLat(d)) begin
                    errors++;
                    $display("[TB] FAIL rand_latency op%0d dut%0d: got %0d, expected %0d", k, d, gotLat[d], expLat(d));
                end
                checks++;
                if (gotBusy[d] !== expLat(d)) begin
                    errors++;
                    $display("[TB] FAIL rand_busy op%0d dut%0d: got %0d cycles, expected %0d", k, d, gotBusy[d], expLat(d));
                end
                checks++;
                if (gotDone[d] !== 1) begin
                    errors++;
                    $display("[TB] FAIL rand_done_count op%0d dut%0d: got %0d, expected 1", k, d, gotDone[d]);
                end
                checks++;
                if (gotSum[d] !== exp) begin
                    errors++;
                    $display("[TB] FAIL rand_sum op%0d dut%0d: first wrong bit %0d, got low %h, expected low %h",
                             k, d, firstDiff(gotSum[d] ^ exp), gotSum[d][31:0], exp[31:0]);
                end
                checks++;
                if (gotSumEnd[d] !== exp) begin
                    errors++;
                    $display("[TB] FAIL rand_sum_hold op%0d dut%0d: first wrong bit %0d",
                             k, d, firstDiff(gotSumEnd[d] ^ exp));
                end
            end
        end
    endtask

    // Extra en pulses land mid-run and, for the LPC=2 build, in its done cycle.
    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
        a   = randWide();
        b   = randWide();
        exp = refSum(a, b);
        runOp(a, b, 2, 15, -1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (gotLat[d] !== expLat(d)) begin
                errors++;
                $display("[TB] FAIL repulse_latency dut%0d: got %0d, expected %0d", d, gotLat[d], expLat(d));
            end
            checks++;
            if (gotDone[d] !== 1) begin
                errors++;
                $display("[TB] FAIL repulse_done_count dut%0d: got %0d, expected 1", d, gotDone[d]);
            end
            checks++;
            if (gotBusy[d] !== expLat(d)) begin
                errors++;
                $display("[TB] FAIL repulse_busy dut%0d: got %0d cycles, expected %0d", d, gotBusy[d], expLat(d));
            end
            checks++;
            if (gotSumEnd[d] !== exp) begin
                errors++;
                $display("[TB] FAIL repulse_sum dut%0d: first wrong bit %0d", d, firstDiff(gotSumEnd[d] ^ exp));
            end
        end
`ifdef CARRY_RESOLVE_ERR_EN
        checks++;
        if (errO[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL repulse_err dut0: got %b, expected 1", errO[0]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
        runOp(randWide(), randWide(), -1, -1, 7);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (rstSumSeen[d] !== '0) begin
                errors++;
                $display("[TB] FAIL midreset_sum dut%0d: got low %h, expected 0", d, rstSumSeen[d][31:0]);
            end
            checks++;
            if (rstBusySeen[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_busy dut%0d: got %b, expected 0", d, rstBusySeen[d]);
            end
            checks++;
            if (gotDone[d] !== 0) begin
                errors++;
                $display("[TB] FAIL midreset_done dut%0d: got %0d pulses, expected 0", d, gotDone[d]);
            end
        end
        a   = randWide();
        b   = randWide();
        exp = refSum(a, b);
        runOp(a, b, -1, -1, -1);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (gotLat[d] !== expLat(d)) begin
                errors++;
                $display("[TB] FAIL after_reset_latency dut%0d: got %0d, expected %0d", d, gotLat[d], expLat(d));
            end
            checks++;
            if (gotSum[d] !== exp) begin
                errors++;
                $display("[TB] FAIL after_reset_sum dut%0d: first wrong bit %0d", d, firstDiff(gotSum[d] ^ exp));
            end
`ifdef CARRY_RESOLVE_ERR_EN
            checks++;
            if (errO[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL after_reset_err dut%0d: got %b, expected 0", d, errO[d]);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        r0    = '0;
        r1    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_zero();
        test_ripple();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
